// File: rtl/ysyx_24070014_decode_alu_imm.sv
// ----------------------------------------------------------------------------
// ysyx_24070014_decode_alu_imm
//
// Single-stage RV32I decode + immediate generation + ALU + branch resolution.
// Everything is computed combinationally from the current inputs. The results
// are captured on the rising edge of clk, so each output reflects the inputs
// sampled at the previous edge.
//
// Ports
//   clk            in   1   clock, all state changes on rising edge
//   reset          in   1   synchronous, active-high; clears every output
//   inst           in  32   RV32I instruction word
//   pc             in  32   address of inst
//   rs1_data       in  32   register read data for inst[19:15]
//   rs2_data       in  32   register read data for inst[24:20]
//   pc_sel         out  1   0 = pc+4, 1 = alu_out is the next PC
//   reg_write_en   out  1   register writeback enable
//   mem_write_en   out  1   store enable
//   writeback_sel  out  2   0 = memory, 1 = ALU, 2 = pc+4
//   imm            out 32   sign-extended immediate (0 for R-type/illegal)
//   alu_out        out 32   ALU result / branch or jump target
//   ecall          out  1   inst is ECALL
//   ebreak         out  1   inst is EBREAK
//   illegal        out  1   unrecognised opcode/funct combination
// ----------------------------------------------------------------------------
module ysyx_24070014_decode_alu_imm (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        pc_sel,
   output logic        reg_write_en,
   output logic        mem_write_en,
   output logic [1:0]  writeback_sel,
   output logic [31:0] imm,
   output logic [31:0] alu_out,
   output logic        ecall,
   output logic        ebreak,
   output logic        illegal
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
   } alu_op_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Immediate formats
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Decode results
   alu_op_t     alu_op;
   logic [31:0] imm_next;
   logic        is_r_type;
   logic        a_is_pc;
   logic        is_jump;
   logic        is_jalr;
   logic        is_branch;
   logic        reg_we_next;
   logic        mem_we_next;
   logic [1:0]  wb_sel_next;
   logic        ecall_next;
   logic        ebreak_next;
   logic        illegal_next;

   // funct3 -> ALU op for the non-alternate encodings shared by OP and OP-IMM
   function automatic alu_op_t base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   always_comb begin
      alu_op       = ALU_ADD;
      imm_next     = 32'd0;
      is_r_type    = 1'b0;
      a_is_pc      = 1'b0;
      is_jump      = 1'b0;
      is_jalr      = 1'b0;
      is_branch    = 1'b0;
      reg_we_next  = 1'b0;
      mem_we_next  = 1'b0;
      wb_sel_next  = 2'd1;
      ecall_next   = 1'b0;
      ebreak_next  = 1'b0;
      illegal_next = 1'b0;

      case (opcode)
         OPC_LUI: begin
            imm_next    = imm_u;
            alu_op      = ALU_COPY_B;
            reg_we_next = 1'b1;
         end
         OPC_AUIPC: begin
            imm_next    = imm_u;
            a_is_pc     = 1'b1;
            reg_we_next = 1'b1;
         end
         OPC_JAL: begin
            imm_next    = imm_j;
            a_is_pc     = 1'b1;
            is_jump     = 1'b1;
            reg_we_next = 1'b1;
            wb_sel_next = 2'd2;
         end
         OPC_JALR: begin
            if (funct3 == 3'b000) begin
               imm_next    = imm_i;
               is_jump     = 1'b1;
               is_jalr     = 1'b1;
               reg_we_next = 1'b1;
               wb_sel_next = 2'd2;
            end else begin
               illegal_next = 1'b1;
            end
         end
         OPC_BRANCH: begin
            // funct3 010/011 are not defined branch conditions
            if (funct3[2:1] != 2'b01) begin
               imm_next  = imm_b;
               a_is_pc   = 1'b1;
               is_branch = 1'b1;
            end else begin
               illegal_next = 1'b1;
            end
         end
         OPC_LOAD: begin
            // LB LH LW LBU LHU
            if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
               imm_next    = imm_i;
               reg_we_next = 1'b1;
               wb_sel_next = 2'd0;
            end else begin
               illegal_next = 1'b1;
            end
         end
         OPC_STORE: begin
            // SB SH SW
            if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
               imm_next    = imm_s;
               mem_we_next = 1'b1;
            end else begin
               illegal_next = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            imm_next    = imm_i;
            reg_we_next = 1'b1;
            alu_op      = base_op(funct3);
            // Only the shift-immediates constrain the upper bits; ADDI and
            // friends use them as immediate, so inst[30] is ignored there.
            if (funct3 == 3'b001) begin
               if (funct7 != F7_BASE) illegal_next = 1'b1;
            end else if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)       alu_op = ALU_SRA;
               else if (funct7 != F7_BASE) illegal_next = 1'b1;
            end
         end
         OPC_OP: begin
            is_r_type   = 1'b1;
            reg_we_next = 1'b1;
            alu_op      = base_op(funct3);
            if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000)      alu_op = ALU_SUB;
               else if (funct3 == 3'b101) alu_op = ALU_SRA;
               else                       illegal_next = 1'b1;
            end else if (funct7 != F7_BASE) begin
               illegal_next = 1'b1;
            end
         end
         OPC_SYSTEM: begin
            imm_next = imm_i;
            if (inst == 32'h0000_0073)      ecall_next   = 1'b1;
            else if (inst == 32'h0010_0073) ebreak_next  = 1'b1;
            else                            illegal_next = 1'b1;
         end
         default: illegal_next = 1'b1;
      endcase

      // An illegal instruction must not have any side effect
      if (illegal_next) begin
         imm_next    = 32'd0;
         is_jump     = 1'b0;
         is_jalr     = 1'b0;
         is_branch   = 1'b0;
         reg_we_next = 1'b0;
         mem_we_next = 1'b0;
      end
   end

   // ALU datapath
   logic [31:0] op_a, op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_res;
   logic [31:0] alu_out_next;

   assign op_a  = a_is_pc ? pc : rs1_data;
   assign op_b  = is_r_type ? rs2_data : imm_next;
   assign shamt = op_b[4:0];

   always_comb begin
      case (alu_op)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_SLL:    alu_res = op_a << shamt;
         ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_SRL:    alu_res = op_a >> shamt;
         ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:     alu_res = op_a | op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_COPY_B: alu_res = op_b;
         default:    alu_res = 32'd0;
      endcase
   end

   always_comb begin
      if (illegal_next)  alu_out_next = 32'd0;
      else if (is_jalr)  alu_out_next = alu_res & 32'hFFFF_FFFE;
      else               alu_out_next = alu_res;
   end

   // Branch condition: always rs1 vs rs2, independent of the ALU operands
   logic branch_taken;

   always_comb begin
      case (funct3)
         3'b000:  branch_taken = (rs1_data == rs2_data);
         3'b001:  branch_taken = (rs1_data != rs2_data);
         3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  branch_taken = (rs1_data <  rs2_data);
         3'b111:  branch_taken = (rs1_data >= rs2_data);
         default: branch_taken = 1'b0;
      endcase
   end

   logic pc_sel_next;
   assign pc_sel_next = is_jump | (is_branch & branch_taken);

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_sel        <= 1'b0;
         reg_write_en  <= 1'b0;
         mem_write_en  <= 1'b0;
         writeback_sel <= 2'd0;
         imm           <= 32'd0;
         alu_out       <= 32'd0;
         ecall         <= 1'b0;
         ebreak        <= 1'b0;
         illegal       <= 1'b0;
      end else begin
         pc_sel        <= pc_sel_next;
         reg_write_en  <= reg_we_next;
         mem_write_en  <= mem_we_next;
         writeback_sel <= wb_sel_next;
         imm           <= imm_next;
         alu_out       <= alu_out_next;
         ecall         <= ecall_next;
         ebreak        <= ebreak_next;
         illegal       <= illegal_next;
      end
   end

endmodule

// File: tb/tb_ysyx_24070014_decode_alu_imm.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24070014_decode_alu_imm.
// Each transaction drives one instruction on the falling edge, pushes the
// reference result onto a queue, and after the next rising edge pops it and
// compares every output.
// ----------------------------------------------------------------------------
module tb_ysyx_24070014_decode_alu_imm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst, pc, rs1_data, rs2_data;
   logic        pc_sel, reg_write_en, mem_write_en, ecall, ebreak, illegal;
   logic [1:0]  writeback_sel;
   logic [31:0] imm, alu_out;

   always #5 clk = ~clk;

   ysyx_24070014_decode_alu_imm dut (
      .clk           (clk),
      .reset         (reset),
      .inst          (inst),
      .pc            (pc),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .pc_sel        (pc_sel),
      .reg_write_en  (reg_write_en),
      .mem_write_en  (mem_write_en),
      .writeback_sel (writeback_sel),
      .imm           (imm),
      .alu_out       (alu_out),
      .ecall         (ecall),
      .ebreak        (ebreak),
      .illegal       (illegal)
   );

   typedef struct {
      logic        pc_sel, rwe, mwe, ec, eb, ill;
      logic [1:0]  wb;
      logic [31:0] imm, alu;
      logic        chk_alu;   // alu_out/writeback_sel are only defined for legal non-system ops
   } exp_t;

   typedef struct {
      logic [31:0] inst, pc, r1, r2;
      logic        rst;
   } vec_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_txn    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want)
         $display("FAIL %s txn=%0d got=%h want=%h", tag, n_txn, got, want);
      else
         n_pass++;
   endtask

   // Reference ALU for OP/OP-IMM; returns ok=0 for undefined funct7 use
   function automatic logic [32:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                           input logic is_imm, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      logic        ok;
      int          sh;
      sh = int'(b[4:0]);
      ok = 1'b1;
      r  = 32'd0;
      case (f3)
         3'd0: begin
            if (is_imm || f7 == 7'h00) r = a + b;
            else if (f7 == 7'h20)      r = a - b;
            else                       ok = 1'b0;
         end
         3'd1: begin r = a << sh; ok = (f7 == 7'h00); end
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: begin
            if (f7 == 7'h00)      r = a >> sh;
            else if (f7 == 7'h20) begin
               r = a >> sh;
               if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end else ok = 1'b0;
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      if (!is_imm && f3 != 3'd0 && f3 != 3'd5 && f7 != 7'h00) ok = 1'b0;
      return {ok, r};
   endfunction

   function automatic exp_t ref_model(input vec_t v);
      exp_t        e;
      logic [31:0] ii, is, ib, iu, ij;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [32:0] ar;
      logic [31:0] w;
      w  = v.inst;
      op = w[6:0];
      f3 = w[14:12];
      ii = {{20{w[31]}}, w[31:20]};
      is = {{20{w[31]}}, w[31:25], w[11:7]};
      ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      iu = {w[31:12], 12'h000};
      ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      e = '{pc_sel:0, rwe:0, mwe:0, ec:0, eb:0, ill:0, wb:2'd1, imm:0, alu:0, chk_alu:1};
      if (v.rst) begin
         e.wb = 2'd0;
         return e;
      end
      case (op)
         7'h37: begin e.imm = iu; e.alu = iu;        e.rwe = 1; end
         7'h17: begin e.imm = iu; e.alu = v.pc + iu; e.rwe = 1; end
         7'h6F: begin e.imm = ij; e.alu = v.pc + ij; e.rwe = 1; e.wb = 2; e.pc_sel = 1; end
         7'h67: begin
            if (f3 == 0) begin
               e.imm = ii; e.alu = (v.r1 + ii) & ~32'd1; e.rwe = 1; e.wb = 2; e.pc_sel = 1;
            end else e.ill = 1;
         end
         7'h63: begin
            e.imm = ib; e.alu = v.pc + ib;
            case (f3)
               3'd0: e.pc_sel = (v.r1 == v.r2);
               3'd1: e.pc_sel = (v.r1 != v.r2);
               3'd4: e.pc_sel = ($signed(v.r1) < $signed(v.r2));
               3'd5: e.pc_sel = !($signed(v.r1) < $signed(v.r2));
               3'd6: e.pc_sel = (v.r1 < v.r2);
               3'd7: e.pc_sel = !(v.r1 < v.r2);
               default: e.ill = 1;
            endcase
         end
         7'h03: begin
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
               e.imm = ii; e.alu = v.r1 + ii; e.rwe = 1; e.wb = 0;
            end else e.ill = 1;
         end
         7'h23: begin
            if (f3 < 3'd3) begin e.imm = is; e.alu = v.r1 + is; e.mwe = 1; end
            else e.ill = 1;
         end
         7'h13: begin
            ar = ref_alu(f3, w[31:25], 1'b1, v.r1, ii);
            e.imm = ii; e.alu = ar[31:0]; e.rwe = 1; e.ill = !ar[32];
         end
         7'h33: begin
            ar = ref_alu(f3, w[31:25], 1'b0, v.r1, v.r2);
            e.alu = ar[31:0]; e.rwe = 1; e.ill = !ar[32];
         end
         7'h73: begin
            e.chk_alu = 0;
            e.imm = ii;
            if (w == 32'h0000_0073)      e.ec = 1;
            else if (w == 32'h0010_0073) e.eb = 1;
            else                         e.ill = 1;
         end
         default: e.ill = 1;
      endcase
      if (e.ill) begin
         e.imm = 0; e.rwe = 0; e.mwe = 0; e.pc_sel = 0; e.chk_alu = 0;
      end
      return e;
   endfunction

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      inst     = v.inst;
      pc       = v.pc;
      rs1_data = v.r1;
      rs2_data = v.r2;
      reset    = v.rst;
      exp_q.push_back(ref_model(v));
      @(posedge clk);
      #1;
      n_txn++;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         $display("txn %0d rst=%0b inst=%h pc=%h rs1=%h rs2=%h -> imm=%h alu=%h pcsel=%0b rwe=%0b mwe=%0b wb=%0d ec=%0b eb=%0b ill=%0b",
                  n_txn, v.rst, v.inst, v.pc, v.r1, v.r2, imm, alu_out, pc_sel,
                  reg_write_en, mem_write_en, writeback_sel, ecall, ebreak, illegal);
         check("pc_sel",       {31'd0, pc_sel},       {31'd0, e.pc_sel});
         check("reg_write_en", {31'd0, reg_write_en}, {31'd0, e.rwe});
         check("mem_write_en", {31'd0, mem_write_en}, {31'd0, e.mwe});
         check("imm",          imm,                   e.imm);
         check("ecall",        {31'd0, ecall},        {31'd0, e.ec});
         check("ebreak",       {31'd0, ebreak},       {31'd0, e.eb});
         check("illegal",      {31'd0, illegal},      {31'd0, e.ill});
         if (e.chk_alu || v.rst) begin
            check("alu_out",       alu_out,                e.alu);
            check("writeback_sel", {30'd0, writeback_sel}, {30'd0, e.wb});
         end
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] b, input logic r);
      vec_t v;
      v.inst = i; v.pc = p; v.r1 = a; v.r2 = b; v.rst = r;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      reset = 1'b1; inst = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
      repeat (2) @(posedge clk);

      vecs.push_back(mk(32'h0050_0093, 32'h0,         32'h0,        32'h0,        1)); // reset state
      vecs.push_back(mk(32'h0050_0093, 32'h0,         32'h0,        32'h0,        0)); // addi x1,x0,5
      vecs.push_back(mk(32'h4020_81B3, 32'h0,         32'h3,        32'h5,        0)); // sub
      vecs.push_back(mk(32'h0020_8463, 32'h8000_0000, 32'h7,        32'h7,        0)); // beq taken
      vecs.push_back(mk(32'h0020_8463, 32'h8000_0000, 32'h7,        32'h8,        0)); // beq not taken
      vecs.push_back(mk(32'hFE20_AE23, 32'h0,         32'h100,      32'h55,       0)); // sw -4
      vecs.push_back(mk(32'h1234_52B7, 32'h0,         32'hDEAD,     32'h0,        0)); // lui
      vecs.push_back(mk(32'h0010_0073, 32'h0,         32'h0,        32'h0,        0)); // ebreak
      vecs.push_back(mk(32'h0000_0073, 32'h0,         32'h0,        32'h0,        0)); // ecall
      vecs.push_back(mk(32'h0050_0093, 32'h0,         32'h9,        32'h0,        1)); // mid-stream reset
      vecs.push_back(mk(32'hFFFF_FFFF, 32'h0,         32'h1,        32'h2,        0)); // illegal
      vecs.push_back(mk(32'h4041_5093, 32'h0,         32'h8000_0000,32'h0,        0)); // srai 4
      vecs.push_back(mk(32'h0020_B1B3, 32'h0,         32'h1,        32'hFFFF_FFFF,0)); // sltu
      vecs.push_back(mk(32'h0100_00EF, 32'h1000,      32'h0,        32'h0,        0)); // jal +16
      vecs.push_back(mk(32'h0031_00E7, 32'h0,         32'h2000,     32'h0,        0)); // jalr 3 -> even
      vecs.push_back(mk(32'h0000_1297, 32'h400,       32'h0,        32'h0,        0)); // auipc
      vecs.push_back(mk(32'hFE20_CEE3, 32'h2000,      32'hFFFF_FFFF,32'h1,        0)); // blt signed taken
      vecs.push_back(mk(32'hFE20_FEE3, 32'h2000,      32'h1,        32'hFFFF_FFFF,0)); // bgeu not taken
      vecs.push_back(mk(32'h0080_A183, 32'h0,         32'h100,      32'h0,        0)); // lw
      vecs.push_back(mk(32'h4020_9093, 32'h0,         32'h1,        32'h0,        0)); // slli bad funct7
      vecs.push_back(mk(32'h4020_C1B3, 32'h0,         32'h1,        32'h2,        0)); // xor with alt funct7
      vecs.push_back(mk(32'h4050_0093, 32'h0,         32'h1,        32'h0,        0)); // addi, inst[30] set
      vecs.push_back(mk(32'h0020_A1B3, 32'h0,         32'h8000_0000,32'h1,        0)); // slt signed
      for (int k = 0; k < 40; k++) begin
         logic [31:0] w;
         logic [6:0]  f7;
         f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
         w  = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
               ($urandom_range(0, 1) == 1) ? 7'h33 : 7'h13};
         vecs.push_back(mk(w, $urandom, $urandom, $urandom, 0));
      end
      vecs.push_back(mk(32'h0050_0093, 32'h0,         32'h0,        32'h0,        1)); // final reset

      foreach (vecs[k]) apply(vecs[k]);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog timeout got=%0d want=%0d", n_checks, 0);
      $fatal(1);
   end

endmodule
